// File: rtl/bus_params_pkg.sv
// Shared bus geometry for the TL-UL fabric: address, data, source-ID and size widths.
package bus_params_pkg;

    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_DBW = BUS_DW / 8;
    localparam int BUS_AIW = 8;
    localparam int BUS_SZW = 2;

endpackage

// File: rtl/tlul_mem_responder_pkg.sv
// Types and helpers for the TL-UL memory responder: channel opcodes, the
// buffered response record and mask helpers.
package tlul_mem_responder_pkg;

    import bus_params_pkg::*;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    typedef struct packed {
        tl_d_op_e             opcode;
        logic [BUS_SZW-1:0]   size;
        logic [BUS_AIW-1:0]   source;
        logic [BUS_DW-1:0]    data;
        logic                 error;
    } resp_entry_t;

    localparam int AddrLsb = $clog2(BUS_DBW);
    localparam int RespW   = $bits(resp_entry_t);

    // Byte lanes touched by an access of 2^size bytes starting at the given lane offset.
    function automatic logic [BUS_DBW-1:0] lane_mask(input logic [BUS_SZW-1:0] size,
                                                     input logic [AddrLsb-1:0] offset);
        logic [BUS_DBW-1:0] m;
        m = '0;
        for (int i = 0; i < BUS_DBW; i++) begin
            if (i < (1 << size)) begin
                m[i] = 1'b1;
            end
        end
        return m << offset;
    endfunction

    // Replicate each byte-enable bit across its eight data bits.
    function automatic logic [BUS_DW-1:0] expand_mask(input logic [BUS_DBW-1:0] m);
        logic [BUS_DW-1:0] r;
        r = '0;
        for (int i = 0; i < BUS_DBW; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/tlul_mem_responder_fifo.sv
// Two-entry response FIFO. Push and pop may occur in the same cycle, including
// when full, in which case the occupancy stays unchanged.
module tlul_mem_responder_fifo
    import tlul_mem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RespW-1:0] push_data,
    input  logic             pop,
    output logic [RespW-1:0] head,
    output logic [1:0]       count
);

    resp_entry_t store_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        push_ok;
    logic        pop_ok;

    // Qualify requests so a stray push into a full FIFO or pop from an empty one is ignored.
    always_comb begin
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q[0] <= '0;
            store_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                store_q[wr_ptr_q] <= resp_entry_t'(push_data);
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = store_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/tlul_mem_responder.sv
// TL-UL device-side responder in front of a single-port word memory with
// 1-cycle read latency. Request checking is enabled by defining
// TLUL_MEM_RESPONDER_ERR_EN; otherwise every request reaches memory and the
// word index wraps modulo Depth.
module tlul_mem_responder
    import bus_params_pkg::*;
    import tlul_mem_responder_pkg::*;
#(
    parameter int Depth = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     a_valid_i,
    output logic                     a_ready_o,
    input  logic [2:0]               a_opcode_i,
    input  logic [BUS_SZW-1:0]       a_size_i,
    input  logic [BUS_AIW-1:0]       a_source_i,
    input  logic [BUS_AW-1:0]        a_address_i,
    input  logic [BUS_DBW-1:0]       a_mask_i,
    input  logic [BUS_DW-1:0]        a_data_i,

    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [2:0]               d_opcode_o,
    output logic [BUS_SZW-1:0]       d_size_o,
    output logic [BUS_AIW-1:0]       d_source_o,
    output logic [BUS_DW-1:0]        d_data_o,
    output logic                     d_error_o,

    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [$clog2(Depth)-1:0] mem_addr_o,
    output logic [BUS_DW-1:0]        mem_wdata_o,
    output logic [BUS_DW-1:0]        mem_wmask_o,
    input  logic [BUS_DW-1:0]        mem_rdata_i
);

    localparam int IdxW = $clog2(Depth);

    logic               accept;
    logic               req_err;
    logic               is_get;
    logic               is_put;

    logic               infl_q;
    tl_d_op_e           infl_op_q;
    logic [BUS_SZW-1:0] infl_size_q;
    logic [BUS_AIW-1:0] infl_source_q;
    logic               infl_err_q;
    logic               infl_read_q;

    resp_entry_t        live_entry;
    resp_entry_t        fifo_head;
    resp_entry_t        d_entry;
    logic [RespW-1:0]   fifo_head_bits;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               d_pop;
    logic [1:0]         occupancy;

    // Decode the request class and the handshake; the request slot counts buffered plus in-flight responses.
    always_comb begin
        is_get    = (a_opcode_i == A_GET);
        is_put    = (a_opcode_i == A_PUT_FULL) || (a_opcode_i == A_PUT_PARTIAL);
        occupancy = fifo_count + {1'b0, infl_q};
        a_ready_o = (occupancy < 2'd2);
        accept    = a_valid_i && a_ready_o;
    end

`ifdef TLUL_MEM_RESPONDER_ERR_EN
    logic [BUS_AW-1:0]  align_mask;
    logic [BUS_DBW-1:0] full_mask;

    // Reject malformed requests so they never touch memory and are answered with an error.
    always_comb begin
        req_err    = 1'b0;
        align_mask = (BUS_AW'(1) << a_size_i) - BUS_AW'(1);
        full_mask  = lane_mask(a_size_i, a_address_i[AddrLsb-1:0]);
        if (!is_get && !is_put) begin
            req_err = 1'b1;
        end
        if (int'(a_size_i) > AddrLsb) begin
            req_err = 1'b1;
        end
        if ((a_address_i & align_mask) != '0) begin
            req_err = 1'b1;
        end
        if ((a_address_i >> AddrLsb) >= BUS_AW'(Depth)) begin
            req_err = 1'b1;
        end
        if ((a_opcode_i == A_PUT_FULL) && (a_mask_i != full_mask)) begin
            req_err = 1'b1;
        end
        if (is_put && (a_mask_i == '0)) begin
            req_err = 1'b1;
        end
    end
`else
    logic unused_bits;

    // Without checking every request is forwarded and the word index simply wraps.
    always_comb begin
        req_err = 1'b0;
    end

    assign unused_bits = ^{a_address_i, d_entry.error};
`endif

    // Memory request is issued in the same cycle as the A handshake.
    always_comb begin
        mem_req_o   = accept && !req_err;
        mem_we_o    = mem_req_o && is_put;
        mem_addr_o  = a_address_i[AddrLsb +: IdxW];
        mem_wdata_o = a_data_i;
        mem_wmask_o = expand_mask(a_mask_i);
    end

    // Capture response metadata for the cycle in which read data returns.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_q        <= 1'b0;
            infl_op_q     <= D_ACCESS_ACK;
            infl_size_q   <= '0;
            infl_source_q <= '0;
            infl_err_q    <= 1'b0;
            infl_read_q   <= 1'b0;
        end else begin
            infl_q <= accept;
            if (accept) begin
                infl_op_q     <= is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                infl_size_q   <= a_size_i;
                infl_source_q <= a_source_i;
                infl_err_q    <= req_err;
                infl_read_q   <= is_get && !req_err;
            end
        end
    end

    // Assemble the response of the in-flight request using the memory data arriving this cycle.
    always_comb begin
        live_entry        = '0;
        live_entry.opcode = infl_op_q;
        live_entry.size   = infl_size_q;
        live_entry.source = infl_source_q;
        live_entry.error  = infl_err_q;
        if (infl_read_q) begin
            live_entry.data = mem_rdata_i;
        end else if (infl_err_q && (infl_op_q == D_ACCESS_ACK_DATA)) begin
            live_entry.data = '1;
        end else begin
            live_entry.data = '0;
        end
    end

    tlul_mem_responder_fifo u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_data (live_entry),
        .pop       (fifo_pop),
        .head      (fifo_head_bits),
        .count     (fifo_count)
    );

    assign fifo_head = resp_entry_t'(fifo_head_bits);

    // Older buffered responses go first; an in-flight response bypasses an empty FIFO so it appears one cycle after accept.
    always_comb begin
        fifo_empty = (fifo_count == 2'd0);
        d_valid_o  = !fifo_empty || infl_q;
        d_pop      = d_valid_o && d_ready_i;
        fifo_pop   = d_pop && !fifo_empty;
        fifo_push  = infl_q && !(fifo_empty && d_pop);
        d_entry    = '0;
        if (!fifo_empty) begin
            d_entry = fifo_head;
        end else if (infl_q) begin
            d_entry = live_entry;
        end
    end

    assign d_opcode_o = d_entry.opcode;
    assign d_size_o   = d_entry.size;
    assign d_source_o = d_entry.source;
    assign d_data_o   = d_entry.data;
`ifdef TLUL_MEM_RESPONDER_ERR_EN
    assign d_error_o  = d_entry.error;
`else
    assign d_error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Self-checking bench for tlul_mem_responder: cycle-by-cycle vector table plus
// a reset-with-buffered-responses sequence. Expectations follow
// TLUL_MEM_RESPONDER_ERR_EN when it is defined.
module tb_tlul_mem_responder;

`ifdef TLUL_MEM_RESPONDER_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    localparam logic [2:0] GET = 3'd4;
    localparam logic [2:0] PF  = 3'd0;
    localparam logic [2:0] PP  = 3'd1;
    localparam int NVEC = 21;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_valid_i;
    logic        a_ready_o;
    logic [2:0]  a_opcode_i;
    logic [1:0]  a_size_i;
    logic [7:0]  a_source_i;
    logic [31:0] a_address_i;
    logic [3:0]  a_mask_i;
    logic [31:0] a_data_i;
    logic        d_valid_o;
    logic        d_ready_i;
    logic [2:0]  d_opcode_o;
    logic [1:0]  d_size_o;
    logic [7:0]  d_source_o;
    logic [31:0] d_data_o;
    logic        d_error_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_wmask_o;
    logic [31:0] mem_rdata_i = '0;

    logic [31:0] bmem [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        a_valid;
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        d_ready;
        logic        e_a_ready;
        logic        e_req;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wmask;
        logic        e_d_valid;
        logic [2:0]  e_d_op;
        logic [1:0]  e_d_size;
        logic [7:0]  e_d_src;
        logic [31:0] e_d_data;
        logic        e_d_err;
    } vec_t;

    vec_t vecs [NVEC];

    tlul_mem_responder #(.Depth(256)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .a_valid_i   (a_valid_i),
        .a_ready_o   (a_ready_o),
        .a_opcode_i  (a_opcode_i),
        .a_size_i    (a_size_i),
        .a_source_i  (a_source_i),
        .a_address_i (a_address_i),
        .a_mask_i    (a_mask_i),
        .a_data_i    (a_data_i),
        .d_valid_o   (d_valid_o),
        .d_ready_i   (d_ready_i),
        .d_opcode_o  (d_opcode_o),
        .d_size_o    (d_size_o),
        .d_source_o  (d_source_o),
        .d_data_o    (d_data_o),
        .d_error_o   (d_error_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Behavioural single-port memory with 1-cycle read latency, preloaded while reset is held.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) begin
                bmem[i] <= 32'h1000_0000 + i;
            end
            bmem[3] <= 32'hDEAD_BEEF;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                bmem[mem_addr_o] <= (bmem[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
            end else begin
                mem_rdata_i <= bmem[mem_addr_o];
            end
        end
    end

    task automatic applyStimulus(input logic av, input logic [2:0] op, input logic [1:0] sz,
                                 input logic [7:0] src, input logic [31:0] addr,
                                 input logic [3:0] mask, input logic [31:0] data, input logic dr);
        a_valid_i   = av;
        a_opcode_i  = op;
        a_size_i    = sz;
        a_source_i  = src;
        a_address_i = addr;
        a_mask_i    = mask;
        a_data_i    = data;
        d_ready_i   = dr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    initial begin
        // Cycle table: inputs | a_ready req we addr wmask | d_valid op size src data err
        vecs[0]  = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, GET, 2'd2, 8'd5,  32'hC,   4'hF, 32'h0,        1'b1,
                     1'b1, 1'b1, 1'b0, 8'd3, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, PF,  2'd2, 8'd6,  32'h10,  4'hF, 32'h1234_5678, 1'b1,
                     1'b1, 1'b1, 1'b1, 8'd4, 32'hFFFF_FFFF, 1'b1, 3'd1, 2'd2, 8'd5, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, PP,  2'd0, 8'd7,  32'hA,   4'h4, 32'h00AB_0000, 1'b1,
                     1'b1, 1'b1, 1'b1, 8'd2, 32'h00FF_0000, 1'b1, 3'd0, 2'd2, 8'd6, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, GET, 2'd2, 8'd8,  32'h10,  4'hF, 32'h0,        1'b1,
                     1'b1, 1'b1, 1'b0, 8'd4, 32'hFFFF_FFFF, 1'b1, 3'd0, 2'd0, 8'd7, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 3'd1, 2'd2, 8'd8, 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, GET, 2'd2, 8'd9,  32'h2,   4'hF, 32'h0,        1'b1,
                     1'b1, !ERR, 1'b0, 8'd0, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, PF,  2'd2, 8'd10, 32'h400, 4'hF, 32'hCAFE_F00D, 1'b1,
                     1'b1, !ERR, !ERR, 8'd0, 32'hFFFF_FFFF, 1'b1, 3'd1, 2'd2, 8'd9,
                     (ERR ? 32'hFFFF_FFFF : 32'h1000_0000), ERR};
        vecs[9]  = '{1'b1, GET, 2'd2, 8'd11, 32'h0,   4'hF, 32'h0,        1'b1,
                     1'b1, 1'b1, 1'b0, 8'd0, 32'hFFFF_FFFF, 1'b1, 3'd0, 2'd2, 8'd10, 32'h0, ERR};
        vecs[10] = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 3'd1, 2'd2, 8'd11,
                     (ERR ? 32'h1000_0000 : 32'hCAFE_F00D), 1'b0};
        vecs[11] = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};
        vecs[12] = '{1'b1, GET, 2'd2, 8'd1,  32'h4,   4'hF, 32'h0,        1'b0,
                     1'b1, 1'b1, 1'b0, 8'd1, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};
        vecs[13] = '{1'b1, GET, 2'd2, 8'd2,  32'h8,   4'hF, 32'h0,        1'b0,
                     1'b1, 1'b1, 1'b0, 8'd2, 32'hFFFF_FFFF, 1'b1, 3'd1, 2'd2, 8'd1, 32'h1000_0001, 1'b0};
        vecs[14] = '{1'b1, GET, 2'd2, 8'd3,  32'hC,   4'hF, 32'h0,        1'b0,
                     1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 3'd1, 2'd2, 8'd1, 32'h1000_0001, 1'b0};
        vecs[15] = '{1'b1, GET, 2'd2, 8'd3,  32'hC,   4'hF, 32'h0,        1'b0,
                     1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 3'd1, 2'd2, 8'd1, 32'h1000_0001, 1'b0};
        vecs[16] = '{1'b1, GET, 2'd2, 8'd3,  32'hC,   4'hF, 32'h0,        1'b1,
                     1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 3'd1, 2'd2, 8'd1, 32'h1000_0001, 1'b0};
        vecs[17] = '{1'b1, GET, 2'd2, 8'd3,  32'hC,   4'hF, 32'h0,        1'b1,
                     1'b1, 1'b1, 1'b0, 8'd3, 32'hFFFF_FFFF, 1'b1, 3'd1, 2'd2, 8'd2, 32'h10AB_0002, 1'b0};
        vecs[18] = '{1'b1, GET, 2'd2, 8'd4,  32'h10,  4'hF, 32'h0,        1'b1,
                     1'b1, 1'b1, 1'b0, 8'd4, 32'hFFFF_FFFF, 1'b1, 3'd1, 2'd2, 8'd3, 32'hDEAD_BEEF, 1'b0};
        vecs[19] = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b1, 3'd1, 2'd2, 8'd4, 32'h1234_5678, 1'b0};
        vecs[20] = '{1'b0, GET, 2'd2, 8'd0,  32'h0,   4'h0, 32'h0,        1'b1,
                     1'b1, 1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 3'd0, 2'd0, 8'd0, 32'h0, 1'b0};

        rst_i = 1'b1;
        applyStimulus(1'b0, GET, 2'd0, 8'd0, 32'h0, 4'h0, 32'h0, 1'b1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk_i);
            applyStimulus(vecs[i].a_valid, vecs[i].op, vecs[i].size, vecs[i].src,
                          vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].d_ready);
            #1;
            checkOutput($sformatf("row%0d.a_ready", i), 32'(a_ready_o), 32'(vecs[i].e_a_ready));
            checkOutput($sformatf("row%0d.mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
            checkOutput($sformatf("row%0d.mem_we", i),  32'(mem_we_o),  32'(vecs[i].e_we));
            if (vecs[i].e_req) begin
                checkOutput($sformatf("row%0d.mem_addr", i),  32'(mem_addr_o), 32'(vecs[i].e_addr));
                checkOutput($sformatf("row%0d.mem_wmask", i), mem_wmask_o,     vecs[i].e_wmask);
                checkOutput($sformatf("row%0d.mem_wdata", i), mem_wdata_o,     vecs[i].data);
            end
            checkOutput($sformatf("row%0d.d_valid", i), 32'(d_valid_o), 32'(vecs[i].e_d_valid));
            if (vecs[i].e_d_valid || i == 0) begin
                checkOutput($sformatf("row%0d.d_opcode", i), 32'(d_opcode_o), 32'(vecs[i].e_d_op));
                checkOutput($sformatf("row%0d.d_size", i),   32'(d_size_o),   32'(vecs[i].e_d_size));
                checkOutput($sformatf("row%0d.d_source", i), 32'(d_source_o), 32'(vecs[i].e_d_src));
                checkOutput($sformatf("row%0d.d_data", i),   d_data_o,        vecs[i].e_d_data);
                checkOutput($sformatf("row%0d.d_error", i),  32'(d_error_o),  32'(vecs[i].e_d_err));
            end
        end

        // Two responses buffered under back-pressure, then reset drops them.
        @(negedge clk_i);
        applyStimulus(1'b1, GET, 2'd2, 8'h11, 32'h4, 4'hF, 32'h0, 1'b0);
        @(negedge clk_i);
        applyStimulus(1'b1, GET, 2'd2, 8'h12, 32'h8, 4'hF, 32'h0, 1'b0);
        @(negedge clk_i);
        applyStimulus(1'b0, GET, 2'd2, 8'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        #1;
        checkOutput("rst_seq.pre_d_valid", 32'(d_valid_o), 32'd1);
        checkOutput("rst_seq.pre_a_ready", 32'(a_ready_o), 32'd0);
        checkOutput("rst_seq.pre_source",  32'(d_source_o), 32'h11);
        @(negedge clk_i);
        checkOutput("rst_seq.held_source", 32'(d_source_o), 32'h11);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_seq.post_d_valid", 32'(d_valid_o), 32'd0);
        checkOutput("rst_seq.post_a_ready", 32'(a_ready_o), 32'd1);
        checkOutput("rst_seq.post_mem_req", 32'(mem_req_o), 32'd0);

        // Normal operation resumes after reset.
        @(negedge clk_i);
        applyStimulus(1'b1, GET, 2'd2, 8'h21, 32'hC, 4'hF, 32'h0, 1'b1);
        #1;
        checkOutput("rst_seq.get_req", 32'(mem_req_o), 32'd1);
        @(negedge clk_i);
        applyStimulus(1'b0, GET, 2'd2, 8'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        #1;
        checkOutput("rst_seq.get_d_valid", 32'(d_valid_o), 32'd1);
        checkOutput("rst_seq.get_source",  32'(d_source_o), 32'h21);
        checkOutput("rst_seq.get_data",    d_data_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        #1;
        checkOutput("rst_seq.drained", 32'(d_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
